// File: rtl/cnn_pkg.sv
// Shared widths, image sizes and state type for the CNN pipeline stages.
package cnn_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 8;
  localparam int BIAS_WIDTH   = 16;
  localparam int ACC_WIDTH    = 24;

  localparam int IMG_IN   = 28;
  localparam int IMG_CONV = 26;
  localparam int IMG_POOL = 13;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } conv_state_t;

endpackage

// File: rtl/conv_window_mac.sv
// Combinational 3x3 window MAC: dot product, bias, ReLU, shift and 8-bit saturation.
module conv_window_mac
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH   = cnn_pkg::DATA_WIDTH,
  parameter int WEIGHT_WIDTH = cnn_pkg::WEIGHT_WIDTH,
  parameter int BIAS_WIDTH   = cnn_pkg::BIAS_WIDTH,
  parameter int ACC_WIDTH    = cnn_pkg::ACC_WIDTH,
  parameter int OUT_SHIFT    = 7
) (
  input  logic        [DATA_WIDTH-1:0]   pixels  [9],
  input  logic signed [WEIGHT_WIDTH-1:0] weights [9],
  input  logic signed [BIAS_WIDTH-1:0]   bias,
  output logic        [DATA_WIDTH-1:0]   result
);

  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + 1;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic        [ACC_WIDTH-1:0]  relu;
  logic        [ACC_WIDTH-1:0]  shifted;

  // Accumulate the nine zero-extended-pixel by signed-weight products onto the bias, then requantise
  always_comb begin
    prod = '0;
    acc  = $signed({{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias});
    for (int i = 0; i < 9; i++) begin
      prod = $signed({1'b0, pixels[i]}) * weights[i];
      acc  = acc + $signed({{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod});
    end
    relu    = acc[ACC_WIDTH-1] ? '0 : acc;
    shifted = relu >> OUT_SHIFT;
    if (shifted > ACC_WIDTH'((2 ** DATA_WIDTH) - 1))
      result = '1;
    else
      result = shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/conv3x3_stage.sv
// Sequential 3x3 valid convolution: one output pixel per clock into a registered output map.
module conv3x3_stage
  import cnn_pkg::*;
#(
  parameter int IN_SIZE      = IMG_IN,
  parameter int DATA_WIDTH   = cnn_pkg::DATA_WIDTH,
  parameter int WEIGHT_WIDTH = cnn_pkg::WEIGHT_WIDTH,
  parameter int BIAS_WIDTH   = cnn_pkg::BIAS_WIDTH,
  parameter int ACC_WIDTH    = cnn_pkg::ACC_WIDTH,
  parameter int OUT_SHIFT    = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic        [DATA_WIDTH-1:0]   data_in  [IN_SIZE*IN_SIZE],
  input  logic signed [WEIGHT_WIDTH-1:0] weights  [9],
  input  logic signed [BIAS_WIDTH-1:0]   bias,
  output logic                           busy,
  output logic                           valid_out,
  output logic        [DATA_WIDTH-1:0]   data_out [(IN_SIZE-2)*(IN_SIZE-2)]
);

  localparam int OUT_SIZE = IN_SIZE - 2;
  localparam int CW = $clog2(OUT_SIZE);
  localparam int AW = $clog2(IN_SIZE * IN_SIZE);
  localparam int OW = $clog2(OUT_SIZE * OUT_SIZE);

  conv_state_t state, next_state;

  logic [CW-1:0] row, col;
  logic          last;
  logic          start;
  logic          write_en;
  logic [AW-1:0] base;
  logic [OW-1:0] widx;
  logic [DATA_WIDTH-1:0] window [9];
  logic [DATA_WIDTH-1:0] mac_out;

  assign last = (row == CW'(OUT_SIZE - 1)) && (col == CW'(OUT_SIZE - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: start on valid_in from IDLE, return after the last pixel
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_in) next_state = RUN;
      RUN:     if (last)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: start strobe, per-cycle write enable and busy level
  always_comb begin
    start    = (state == IDLE) && valid_in;
    write_en = (state == RUN);
    busy     = (state == RUN);
  end

  // Select the 3x3 input window whose top-left corner sits at (row, col)
  always_comb begin
    base = AW'(row) * AW'(IN_SIZE) + AW'(col);
    widx = OW'(row) * OW'(OUT_SIZE) + OW'(col);
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        window[ky*3+kx] = data_in[base + AW'(ky*IN_SIZE + kx)];
  end

  conv_window_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .BIAS_WIDTH  (BIAS_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .OUT_SHIFT   (OUT_SHIFT)
  ) u_mac (
    .pixels (window),
    .weights(weights),
    .bias   (bias),
    .result (mac_out)
  );

  // Row/column scan and the level-style completion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      valid_out <= 1'b0;
    end else if (start) begin
      row       <= '0;
      col       <= '0;
      valid_out <= 1'b0;
    end else if (write_en) begin
      if (last) begin
        row       <= '0;
        col       <= '0;
        valid_out <= 1'b1;
      end else if (col == CW'(OUT_SIZE - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output map: one entry written per RUN cycle, others hold their previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_SIZE*OUT_SIZE; i++) data_out[i] <= '0;
    end else if (write_en) begin
      data_out[widx] <= mac_out;
    end
  end

endmodule

// File: tb/tb_conv3x3_stage.sv
// Directed self-checking bench for conv3x3_stage at default parameters.
module tb_conv3x3_stage;

  localparam int NIN  = 28 * 28;
  localparam int NOUT = 26 * 26;

  logic clk;
  logic rst;
  logic valid_in;
  logic        [7:0]  data_in  [NIN];
  logic signed [7:0]  weights  [9];
  logic signed [15:0] bias;
  logic busy;
  logic valid_out;
  logic [7:0] data_out [NOUT];

  int tests_run;
  int tests_failed;

  conv3x3_stage dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .weights  (weights),
    .bias     (bias),
    .busy     (busy),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic fill(input int pix, input int w, input int b);
    for (int i = 0; i < NIN; i++) data_in[i] = 8'(pix);
    for (int i = 0; i < 9; i++) weights[i] = 8'(w);
    bias = 16'(b);
  endtask

  // Leaves the caller at the falling edge right after the start edge
  task automatic start_run();
    @(negedge clk);
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!valid_out && edges < 2000) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    int bad;
    tests_run++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags busy=%b valid_out=%b required 0 0", busy, valid_out);
    end
    bad = 0;
    for (int i = 0; i < NOUT; i++) if (data_out[i] !== 8'd0) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_map %0d nonzero entries, required 0", bad);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_uniform();
    int edges, bc, bad, first;
    fill(8, 16, 0);
    start_run();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL uniform_busy_rise busy=%b required 1", busy);
    end
    wait_done(edges, bc);
    tests_run++;
    if (edges != 676) begin
      tests_failed++;
      $display("[TB] FAIL uniform_latency valid_out after %0d edges, required 676", edges);
    end
    tests_run++;
    if (bc != 676) begin
      tests_failed++;
      $display("[TB] FAIL uniform_busy_len busy %0d cycles, required 676", bc);
    end
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++)
      if (data_out[i] !== 8'd9) begin bad++; if (first < 0) first = i; end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL uniform_map %0d wrong, first idx %0d got %0d required 9", bad, first, data_out[first]);
    end
  endtask

  task automatic test_saturate();
    int edges, bc, bad, first;
    fill(255, 127, 0);
    start_run();
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sat_valid_clear valid_out=%b required 0", valid_out);
    end
    wait_done(edges, bc);
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++)
      if (data_out[i] !== 8'd255) begin bad++; if (first < 0) first = i; end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL saturate_map %0d wrong, first idx %0d got %0d required 255", bad, first, data_out[first]);
    end
  endtask

  task automatic test_relu_bias();
    int edges, bc, bad, first;
    fill(10, -1, 0);
    start_run();
    wait_done(edges, bc);
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++)
      if (data_out[i] !== 8'd0) begin bad++; if (first < 0) first = i; end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL relu_map %0d wrong, first idx %0d got %0d required 0", bad, first, data_out[first]);
    end
    tests_run++;
    if (valid_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL relu_valid_held valid_out=%b required 1", valid_out);
    end
    bias = 16'sd1280;
    start_run();
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rerun_valid_clear valid_out=%b required 0", valid_out);
    end
    repeat (11) begin @(posedge clk); @(negedge clk); end
    tests_run++;
    if (data_out[0] !== 8'd9 || data_out[675] !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL rerun_partial out[0]=%0d out[675]=%0d required 9 0", data_out[0], data_out[675]);
    end
    wait_done(edges, bc);
    tests_run++;
    if (edges + 11 != 676) begin
      tests_failed++;
      $display("[TB] FAIL rerun_latency valid_out after %0d edges, required 676", edges + 11);
    end
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++)
      if (data_out[i] !== 8'd9) begin bad++; if (first < 0) first = i; end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL bias_map %0d wrong, first idx %0d got %0d required 9", bad, first, data_out[first]);
    end
  endtask

  task automatic test_impulse();
    int edges, bc, bad, first;
    logic [7:0] exp_v;
    fill(0, 0, 0);
    data_in[5*28+7] = 8'd200;
    weights[4] = 8'sd127;
    start_run();
    wait_done(edges, bc);
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++) begin
      exp_v = (i == 4*26+6) ? 8'd198 : 8'd0;
      if (data_out[i] !== exp_v) begin bad++; if (first < 0) first = i; end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL impulse_center %0d wrong, first idx %0d got %0d (198 only at idx 110)", bad, first, data_out[first]);
    end
    weights[4] = 8'sd0;
    weights[0] = 8'sd127;
    start_run();
    wait_done(edges, bc);
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++) begin
      exp_v = (i == 5*26+7) ? 8'd198 : 8'd0;
      if (data_out[i] !== exp_v) begin bad++; if (first < 0) first = i; end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL impulse_corner %0d wrong, first idx %0d got %0d (198 only at idx 137)", bad, first, data_out[first]);
    end
  endtask

  task automatic test_ignore_restart();
    int edges, bad, first;
    fill(8, 16, 0);
    start_run();
    edges = 0;
    while (!valid_out && edges < 2000) begin
      if (edges == 100) valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      edges++;
    end
    tests_run++;
    if (edges != 676) begin
      tests_failed++;
      $display("[TB] FAIL ignore_latency valid_out after %0d edges, required 676", edges);
    end
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++)
      if (data_out[i] !== 8'd9) begin bad++; if (first < 0) first = i; end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL ignore_map %0d wrong, first idx %0d got %0d required 9", bad, first, data_out[first]);
    end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    tests_run++;
    if (busy !== 1'b0 || valid_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ignore_no_requeue busy=%b valid_out=%b required 0 1", busy, valid_out);
    end
  endtask

  task automatic test_mid_reset();
    int edges, bc, bad, first;
    fill(8, 16, 0);
    start_run();
    repeat (300) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < NOUT; i++) if (data_out[i] !== 8'd0) bad++;
    tests_run++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear busy=%b valid_out=%b nonzero=%0d required 0 0 0", busy, valid_out, bad);
    end
    @(negedge clk);
    rst = 1'b0;
    start_run();
    wait_done(edges, bc);
    tests_run++;
    if (edges != 676 || bc != 676) begin
      tests_failed++;
      $display("[TB] FAIL midreset_rerun edges=%0d busy=%0d required 676 676", edges, bc);
    end
    bad = 0; first = -1;
    for (int i = 0; i < NOUT; i++)
      if (data_out[i] !== 8'd9) begin bad++; if (first < 0) first = i; end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_map %0d wrong, first idx %0d got %0d required 9", bad, first, data_out[first]);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clk = 1'b0;
    rst = 1'b1;
    valid_in = 1'b0;
    fill(0, 0, 0);
    #22;
    test_reset();
    test_uniform();
    test_saturate();
    test_relu_bias();
    test_impulse();
    test_ignore_restart();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/conv3x3_stage.md
Name: conv3x3_stage

Overview:
- Sequential single-channel 3x3 valid-convolution stage feeding the 2x2 max-pool stage.
- Input is a 28x28 unsigned feature map; output is a 26x26 map presented in the same flat-array form the pool stage consumes.
- Computes one output pixel per clock: dot product, then bias, ReLU, right-shift requantise and saturate to 8 bits.
- Run is started by `valid_in`; `valid_out` stays high after completion until the next start.

Parameters:
- IN_SIZE, 28, width/height of input map.
- OUT_SIZE, IN_SIZE-2, width/height of output map (derived, not overridden).
- DATA_WIDTH, 8, unsigned pixel width (in and out).
- WEIGHT_WIDTH, 8, signed kernel tap width.
- BIAS_WIDTH, 16, signed bias width.
- ACC_WIDTH, 24, signed accumulator width.
- OUT_SHIFT, 7, arithmetic right shift applied after ReLU.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  start request; sampled only in IDLE.
- data_in  in  DATA_WIDTH x IN_SIZE*IN_SIZE  input map, row-major.
- weights  in  WEIGHT_WIDTH x 9  kernel; index ky*3+kx, signed.
- bias  in  BIAS_WIDTH  signed bias.
- busy  out  1  high while RUN.
- valid_out  out  1  output map complete and stable.
- data_out  out  DATA_WIDTH x OUT_SIZE*OUT_SIZE  output map, row-major.

Behaviour:
- Reset (async): state=IDLE, row=col=0, busy=0, valid_out=0, every data_out entry=0.
- States:
  - IDLE: if valid_in, go to RUN; row=col=0; busy<=1; valid_out<=0.
  - RUN: each edge writes data_out[row*OUT_SIZE+col] and advances col, wrapping to 0 with row+1.
  - Last pixel (row=col=OUT_SIZE-1): written at the same edge that sets state<=IDLE, busy<=0, valid_out<=1.
- Latency:
  - Start accepted at edge E.
  - Pixel k written at edge E+1+k.
  - valid_out rises at edge E+OUT_SIZE², which is E+676 at defaults.
  - busy is high for exactly 676 cycles.
- valid_in while RUN: ignored, no restart, no queueing.
- valid_in in IDLE with valid_out=1: new run starts; valid_out clears at that edge.
- data_out entries not yet rewritten keep their previous-run values until overwritten.
- data_in, weights and bias are not latched. The producer holds them stable from the start edge until valid_out rises; behaviour is undefined otherwise.
- Arithmetic per output (r,c):
  - Product: zero-extended pixel at (r+ky, c+kx) times signed weight[ky*3+kx], 17-bit signed.
  - Sum of the 9 products plus sign-extended bias, in ACC_WIDTH signed; no overflow possible at defaults.
  - ReLU: negative sums become 0.
  - Shift: >> OUT_SHIFT, truncating.
  - Saturate: values above 2^DATA_WIDTH-1 become 255.
- Reset mid-RUN: immediate abort to reset state; the next valid_in runs a full 676-cycle pass.
- valid_out is level, not pulse, so a downstream stage that samples valid_in as a level sees stable data.

Decomposition:
- Package cnn_pkg holds:
  - DATA_WIDTH, WEIGHT_WIDTH, BIAS_WIDTH, ACC_WIDTH defaults;
  - IMG_IN=28, IMG_CONV=26, IMG_POOL=13;
  - conv_state_t enum {IDLE, RUN}.
- Sub-module conv_window_mac (combinational) covers 9 pixels, 9 weights and bias in, one saturated 8-bit pixel out. It contains the multiply, sum, ReLU, shift and saturate.
- conv3x3_stage holds the FSM, row/col counters, window address mux and output registers.

Test Plan:
All cases run at the defaults (OUT_SHIFT=7).
1. All pixels 8, all weights 16, bias 0, start -> every output 9 (1152>>7). busy high 676 cycles; valid_out rises exactly 676 edges after the start edge.
2. All pixels 255, all weights 127, bias 0 -> sum 291465 saturates; every output 255.
3. All pixels 10, all weights -1 -> bias 0 gives 0 (ReLU). Rerun with bias 1280 -> 9 (1190>>7). valid_out clears on the rerun start edge.
4. Impulse 200 at input (5,7), rest 0; only weights[4]=127 -> out(4,6)=198, all others 0. Weights[0]=127 only -> out(5,7)=198.
5. Start, then pulse valid_in at cycle 100 of RUN -> ignored; valid_out still at edge 676, outputs correct.
6. Assert rst at RUN cycle 300 -> busy, valid_out and all data_out are 0 immediately. A restart yields a full, correct 676-cycle run.
